ddr_lite_req_queue: RTL and testbench

DDR_LITE_REQ_QUEUE -- requirements
Module: ddr_lite_req_queue

---
 rtl/ddr_lite_req_queue.sv | 169 ++++++++++++++++
 tb/tb_ddr_lite_req_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_lite_req_queue.sv
// Request FIFO plus issue FSM for a lightweight DDR controller front end.
// Define DDR_LITE_RDTIMEOUT_EN to add a read watchdog that answers stuck reads with an error response.
module ddr_lite_req_queue #(
    parameter int DATA_W     = 16,
    parameter int APP_AW     = 24,
    parameter int DEPTH      = 4,
    parameter int WR_GAP     = 8,
    parameter int RD_TIMEOUT = 64,
    localparam int DQM_W     = (DATA_W / 8 > 1) ? DATA_W / 8 : 1,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [APP_AW-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DQM_W-1:0]  req_dqm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              app_req,
    output logic              app_we,
    output logic [APP_AW-1:0] app_addr,
    output logic [DATA_W-1:0] app_wdata,
    output logic [DQM_W-1:0]  app_dqm,
    input  logic [DATA_W-1:0] app_rdata,
    input  logic              app_rvalid,
    output logic [LVL_W-1:0]  level,
    output logic              err_spurious
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENT_W   = 1 + APP_AW + DATA_W + DQM_W;
    localparam int CNT_MAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push, pop, empty, full;
    logic [ENT_W-1:0]  head;
    logic              head_we;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              app_req_q, app_we_q;
    logic [APP_AW-1:0] app_addr_q;
    logic [DATA_W-1:0] app_wdata_q;
    logic [DQM_W-1:0]  app_dqm_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_spurious_q;
`ifdef DDR_LITE_RDTIMEOUT_EN
    logic              rsp_err_q;
`endif

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign push    = req_valid && !full;
    assign head    = mem_q[rd_ptr_q];
    assign head_we = head[ENT_W-1];
    // Reads wait while a response is still pending; writes never do.
    assign pop     = (state_q == IDLE) && !empty && (head_we || !rsp_valid_q);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge ck) begin
        if (push) mem_q[wr_ptr_q] <= {req_we, req_addr, req_wdata, req_dqm};
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            app_req_q      <= 1'b0;
            app_we_q       <= 1'b0;
            app_addr_q     <= '0;
            app_wdata_q    <= '0;
            app_dqm_q      <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            err_spurious_q <= 1'b0;
`ifdef DDR_LITE_RDTIMEOUT_EN
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            app_req_q <= 1'b0;
            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
            if (app_rvalid && state_q != RD_WAIT) err_spurious_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        app_req_q <= 1'b1;
                        {app_we_q, app_addr_q, app_wdata_q, app_dqm_q} <= head;
                        cnt_q   <= CNT_W'(1);
                        state_q <= head_we ? WR_WAIT : RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WR_GAP - 1)) state_q <= IDLE;
                end
                RD_WAIT: begin
                    // Only the first beat is taken; later beats land in IDLE and flag err_spurious.
                    if (app_rvalid) begin
                        rsp_data_q  <= app_rdata;
                        rsp_valid_q <= 1'b1;
`ifdef DDR_LITE_RDTIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
`ifdef DDR_LITE_RDTIMEOUT_EN
                    else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = !full;
    assign level        = level_q;
    assign app_req      = app_req_q;
    assign app_we       = app_we_q;
    assign app_addr     = app_addr_q;
    assign app_wdata    = app_wdata_q;
    assign app_dqm      = app_dqm_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign err_spurious = err_spurious_q;
`ifdef DDR_LITE_RDTIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_lite_req_queue.sv
// Directed bench for ddr_lite_req_queue with request/response scoreboards and a simple controller model.
// Build with DDR_LITE_RDTIMEOUT_EN defined to exercise the read watchdog.
module tb_ddr_lite_req_queue;

    localparam int DATA_W = 16, APP_AW = 24, DEPTH = 4, WR_GAP = 8, RD_TIMEOUT = 64;
    localparam int DQM_W = 2, LVL_W = 3;

    logic              ck = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0, req_we = 1'b0;
    logic [APP_AW-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [DQM_W-1:0]  req_dqm = '0;
    logic              req_ready;
    logic              rsp_valid, rsp_err;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              app_req, app_we;
    logic [APP_AW-1:0] app_addr;
    logic [DATA_W-1:0] app_wdata, app_rdata;
    logic [DQM_W-1:0]  app_dqm;
    logic              app_rvalid;
    logic [LVL_W-1:0]  level;
    logic              err_spurious;

    logic              mdl_rvalid = 1'b0, frc_rvalid = 1'b0, ctrl_en = 1'b1;
    logic [DATA_W-1:0] mdl_rdata = '0;
    assign app_rvalid = mdl_rvalid | frc_rvalid;
    assign app_rdata  = mdl_rdata;

    ddr_lite_req_queue #(
        .DATA_W(DATA_W), .APP_AW(APP_AW), .DEPTH(DEPTH), .WR_GAP(WR_GAP), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .ck(ck), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dqm(req_dqm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .app_req(app_req), .app_we(app_we), .app_addr(app_addr), .app_wdata(app_wdata),
        .app_dqm(app_dqm), .app_rdata(app_rdata), .app_rvalid(app_rvalid),
        .level(level), .err_spurious(err_spurious)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic              we;
        logic [APP_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DQM_W-1:0]  dqm;
    } req_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    req_t app_exp_q[$];
    rsp_t rsp_exp_q[$];
    logic [DATA_W-1:0] shadow   [logic [APP_AW-1:0]];
    logic [DATA_W-1:0] ctrl_mem [logic [APP_AW-1:0]];

    int checks = 0, errors = 0, cyc = 0;
    int n_issue = 0, last_rd_cyc = 0, exp_lat = 6, rd_pend = 0, n0 = 0;
    int issue_cyc[$];
    logic app_req_prev = 1'b0, rsp_valid_prev = 1'b0;
    logic [APP_AW-1:0] rd_addr = '0;
    req_t exp_req;
    rsp_t exp_rsp;

    always @(posedge ck) cyc++;

    function automatic logic [DATA_W-1:0] bg(input logic [APP_AW-1:0] a);
        return a[DATA_W-1:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [DATA_W-1:0] rd_shadow(input logic [APP_AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : bg(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: writes update its memory, reads answer 5 cycles after app_req.
    always @(negedge ck) begin
        mdl_rvalid = 1'b0;
        if (rst) begin
            rd_pend = 0;
        end else begin
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    mdl_rvalid = 1'b1;
                    mdl_rdata  = ctrl_mem.exists(rd_addr) ? ctrl_mem[rd_addr] : bg(rd_addr);
                end
            end
            if (app_req && ctrl_en) begin
                if (app_we) ctrl_mem[app_addr] = app_wdata;
                else begin
                    rd_pend = 5;
                    rd_addr = app_addr;
                end
            end
        end
    end

    // Monitors: issued requests and completed responses against the scoreboards.
    always @(negedge ck) begin
        if (!rst) begin
            if (app_req) begin
                n_issue++;
                issue_cyc.push_back(cyc);
                check("app_req_pulse", 64'(app_req_prev), 64'd0);
                check("app_req_expected", 64'(app_exp_q.size() != 0), 64'd1);
                if (app_exp_q.size() != 0) begin
                    exp_req = app_exp_q.pop_front();
                    check("app_issue", 64'({app_we, app_addr, app_wdata, app_dqm}), 64'(exp_req));
                end
                if (!app_we) last_rd_cyc = cyc;
            end
            if (rsp_valid && !rsp_valid_prev)
                check("rsp_latency", 64'(cyc - last_rd_cyc), 64'(exp_lat));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(rsp_exp_q.size() != 0), 64'd1);
                if (rsp_exp_q.size() != 0) begin
                    exp_rsp = rsp_exp_q.pop_front();
                    check("rsp_data_err", 64'({rsp_data, rsp_err}), 64'(exp_rsp));
                end
            end
        end
        app_req_prev   = app_req;
        rsp_valid_prev = rsp_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    // mode: 0 normal read response, 1 timeout response, 2 no response expected
    task automatic push_req(input logic we, input logic [APP_AW-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DQM_W-1:0] m, input int mode);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_dqm = m;
        @(negedge ck);
        while (!req_ready && n < 300) begin
            @(negedge ck);
            n++;
        end
        check("push_accept", 64'(req_ready), 64'd1);
        @(posedge ck); #1;
        req_valid = 1'b0;
        app_exp_q.push_back({we, a, d, m});
        if (we) shadow[a] = d;
        else if (mode == 0) rsp_exp_q.push_back({rd_shadow(a), 1'b0});
        else if (mode == 1) rsp_exp_q.push_back({16'h0000, 1'b1});
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((app_exp_q.size() != 0 || rsp_exp_q.size() != 0 || rsp_valid) && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(app_exp_q.size() == 0 && rsp_exp_q.size() == 0 && !rsp_valid), 64'd1);
        tick(WR_GAP + 2);
    endtask

    task automatic wait_rsp_valid(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_app_req"}, 64'(app_req), 64'd0);
        check({tag, "_app_we"}, 64'(app_we), 64'd0);
        check({tag, "_app_addr"}, 64'(app_addr), 64'd0);
        check({tag, "_app_wdata"}, 64'(app_wdata), 64'd0);
        check({tag, "_app_dqm"}, 64'(app_dqm), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_err_spurious"}, 64'(err_spurious), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        check_reset("por");
        rst = 1'b0;
        tick(2);

        // Write then read back through the controller model
        n0 = n_issue;
        push_req(1'b1, 24'h10, 16'hBEEF, 2'b00, 0);
        push_req(1'b0, 24'h10, 16'h0000, 2'b00, 0);
        wait_drain("s1_drain", 200);
        check("s1_issue_count", 64'(n_issue - n0), 64'd2);

        // Back-to-back writes are spaced by WR_GAP
        n0 = n_issue;
        push_req(1'b1, 24'h20, 16'h1111, 2'b01, 0);
        push_req(1'b1, 24'h21, 16'h2222, 2'b10, 0);
        push_req(1'b1, 24'h22, 16'h3333, 2'b11, 0);
        wait_drain("s2_drain", 200);
        check("s2_issue_count", 64'(n_issue - n0), 64'd3);
        check("s2_gap1", 64'(issue_cyc[n0 + 1] - issue_cyc[n0]), 64'(WR_GAP));
        check("s2_gap2", 64'(issue_cyc[n0 + 2] - issue_cyc[n0 + 1]), 64'(WR_GAP));

        // Fill the FIFO behind a held response
        rsp_ready = 1'b0;
        n0 = n_issue;
        push_req(1'b0, 24'h30, 16'h0, 2'b00, 0);
        wait_rsp_valid("s3_rsp_held", 50);
        for (int i = 1; i <= 4; i++) push_req(1'b0, 24'h30 + 24'(i), 16'h0, 2'b00, 0);
        tick(2);
        check("s3_level_full", 64'(level), 64'd4);
        check("s3_ready_low", 64'(req_ready), 64'd0);
        fork
            push_req(1'b0, 24'h35, 16'h0, 2'b00, 0);
            begin
                tick(5);
                check("s3_level_hold", 64'(level), 64'd4);
                check("s3_ready_hold", 64'(req_ready), 64'd0);
                check("s3_no_issue", 64'(n_issue - n0), 64'd1);
                rsp_ready = 1'b1;
            end
        join
        check("s3_fifth_after_pop", 64'(n_issue - n0), 64'd2);
        check("s3_level_refill", 64'(level), 64'd4);
        wait_drain("s3_drain", 400);
        check("s3_issue_count", 64'(n_issue - n0), 64'd6);

        // Write overtakes a stalled read; second read waits for the handshake
        rsp_ready = 1'b0;
        n0 = n_issue;
        push_req(1'b0, 24'h40, 16'h0, 2'b00, 0);
        wait_rsp_valid("s4_rsp_held", 50);
        push_req(1'b1, 24'h41, 16'hA5A5, 2'b11, 0);
        push_req(1'b0, 24'h41, 16'h0, 2'b00, 0);
        tick(20);
        check("s4_issue_count_stalled", 64'(n_issue - n0), 64'd2);
        check("s4_level", 64'(level), 64'd1);
        check("s4_last_issue_write", 64'({app_we, app_addr}), 64'({1'b1, 24'h41}));
        check("s4_rsp_still_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        wait_drain("s4_drain", 200);
        check("s4_issue_count", 64'(n_issue - n0), 64'd3);

        // Spurious read data in IDLE
        check("s5_spurious_clear", 64'(err_spurious), 64'd0);
        frc_rvalid = 1'b1;
        tick(1);
        frc_rvalid = 1'b0;
        tick(1);
        check("s5_spurious_set", 64'(err_spurious), 64'd1);
        check("s5_no_capture", 64'(rsp_valid), 64'd0);
        tick(10);
        check("s5_spurious_sticky", 64'(err_spurious), 64'd1);

        // Read with no controller answer
        ctrl_en = 1'b0;
        n0 = n_issue;
`ifdef DDR_LITE_RDTIMEOUT_EN
        exp_lat = RD_TIMEOUT;
        push_req(1'b0, 24'h50, 16'h0, 2'b00, 1);
        wait_drain("s6_timeout_drain", 300);
        check("s6_timeout_issue", 64'(n_issue - n0), 64'd1);
        exp_lat = 6;
`else
        push_req(1'b0, 24'h50, 16'h0, 2'b00, 2);
        tick(RD_TIMEOUT + 16);
        check("s6_no_timeout_valid", 64'(rsp_valid), 64'd0);
        check("s6_no_timeout_err", 64'(rsp_err), 64'd0);
        check("s6_read_issued", 64'(n_issue - n0), 64'd1);
`endif

        // Reset while a read is outstanding and more requests are queued
        push_req(1'b0, 24'h60, 16'h0, 2'b00, 2);
        push_req(1'b1, 24'h61, 16'h1111, 2'b01, 2);
        tick(3);
        @(posedge ck); #3;
        rst = 1'b1;
        #1;
        check_reset("mid");
        app_exp_q.delete();
        rsp_exp_q.delete();
        @(posedge ck); #1;
        rst = 1'b0;
        ctrl_en = 1'b1;
        n0 = n_issue;
        tick(RD_TIMEOUT + 16);
        check("rst_no_issue", 64'(n_issue - n0), 64'd0);
        check("rst_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);

        // Normal traffic resumes after reset
        n0 = n_issue;
        push_req(1'b1, 24'h70, 16'h1234, 2'b01, 0);
        push_req(1'b0, 24'h70, 16'h0, 2'b00, 0);
        wait_drain("post_rst_drain", 200);
        check("post_rst_issue_count", 64'(n_issue - n0), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
